// File: rtl/gowin_ff_test_pkg.sv
// Shared constants, FSM states and mode helpers for the Gowin flop exerciser.
package gowin_ff_test_pkg;

  localparam int MODE_PLAIN    = 0;
  localparam int MODE_CE       = 1;
  localparam int MODE_SET      = 2;
  localparam int MODE_RESET    = 3;
  localparam int MODE_CE_SET   = 4;
  localparam int MODE_CE_RESET = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHK_INIT,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR map to bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic has_ce(input int mode);
    return (mode == MODE_CE) || (mode == MODE_CE_SET) || (mode == MODE_CE_RESET);
  endfunction

  function automatic logic has_sr(input int mode);
    return (mode >= MODE_SET) && (mode <= MODE_CE_RESET);
  endfunction

  // Value the flop takes while its set/reset control is asserted.
  function automatic logic sr_val(input int mode);
    return (mode == MODE_SET) || (mode == MODE_CE_SET);
  endfunction

endpackage

// File: rtl/gowin_ff_exerciser_if.sv
// Signal bundle between the exerciser (master) and the flop under test (slave).
interface gowin_ff_exerciser_if;
  logic Q_I;
  logic D_O;
  logic CE_O;
  logic SR_O;

  modport master (input Q_I, output D_O, CE_O, SR_O);
  modport slave  (output Q_I, input D_O, CE_O, SR_O);
endinterface

// File: rtl/ff_lfsr16.sv
// 16-bit Fibonacci LFSR with seed load and advance enable. Exposes the low
// bits of the value it will hold after the coming edge, so the caller can
// register stimulus that lines up with the LFSR step.
module ff_lfsr16 import gowin_ff_test_pkg::*; #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic       i_adv,
  output logic [5:0] o_next_bits
);

  logic [15:0] r_lfsr;
  logic [15:0] w_lfsr_next;
  logic        w_fb;

  assign w_fb        = ^(r_lfsr & LFSR_TAPS);
  assign o_next_bits = w_lfsr_next[5:0];

  // Load wins over advance; otherwise hold.
  always_comb begin
    w_lfsr_next = r_lfsr;
    if (i_load) begin
      w_lfsr_next = SEED;
    end else if (i_adv) begin
      w_lfsr_next = {w_fb, r_lfsr[15:1]};
    end
  end

  // LFSR state register, back to the seed on reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= w_lfsr_next;
    end
  end

endmodule

// File: rtl/gowin_ff_exerciser.sv
// Stimulus generator and checker for one Gowin single-bit flop variant.
// Drives D/CE/SR into the flop, tracks the expected Q with a reference
// model and counts mismatches over a run of pseudo-random vectors.
module gowin_ff_exerciser import gowin_ff_test_pkg::*; #(
  parameter int          MODE        = 0,
  parameter bit          ASYNC       = 1'b0,
  parameter logic        INIT        = 1'b0,
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int          NUM_VECTORS = 256
) (
  input  logic                 CLK,
  input  logic                 CLEAR,
  input  logic                 START,
  gowin_ff_exerciser_if.master ff,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 PASS,
  output logic [15:0]          ERR_CNT
);

  localparam logic        C_HAS_CE   = has_ce(MODE);
  localparam logic        C_HAS_SR   = has_sr(MODE);
  localparam logic        C_SR_VAL   = sr_val(MODE);
  localparam logic        C_CE_IDLE  = ~C_HAS_CE;
  localparam logic        C_ASYNC_SR = ASYNC && C_HAS_SR;
  localparam logic [15:0] C_LAST_VEC = 16'(NUM_VECTORS - 1);

  state_t      r_state, w_state_next;
  logic        r_d, r_ce, r_sr;
  logic        w_d_next, w_ce_next, w_sr_next;
  logic        r_busy, r_done, r_pass;
  logic        w_busy_next, w_done_next;
  logic [15:0] r_err_cnt, w_err_next;
  logic [15:0] r_vec_cnt, w_vec_next;
  logic        r_exp, r_settle;
  logic        w_exp_eff, w_cmp_en;
  logic        w_lfsr_load, w_lfsr_adv;
  logic [5:0]  w_lfsr_bits;

  ff_lfsr16 #(.SEED(SEED)) u_lfsr (
    .i_clk       (CLK),
    .i_rst       (CLEAR),
    .i_load      (w_lfsr_load),
    .i_adv       (w_lfsr_adv),
    .o_next_bits (w_lfsr_bits)
  );

  // An async preset/clear forces Q immediately, ahead of the clocked model.
  assign w_exp_eff = (C_ASYNC_SR && r_sr) ? C_SR_VAL : r_exp;

  // Next-state, run bookkeeping and saturating mismatch count.
  always_comb begin
    w_state_next = r_state;
    w_busy_next  = r_busy;
    w_done_next  = r_done;
    w_err_next   = r_err_cnt;
    w_vec_next   = r_vec_cnt;
    w_cmp_en     = 1'b0;
    w_lfsr_load  = 1'b0;
    w_lfsr_adv   = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (START && r_settle) begin
          w_state_next = C_HAS_CE ? ST_CHK_INIT : ST_RUN;
          w_busy_next  = 1'b1;
          w_done_next  = 1'b0;
          w_err_next   = 16'd0;
          w_vec_next   = 16'd0;
          w_lfsr_load  = 1'b1;
        end
      end
      ST_CHK_INIT: begin
        w_cmp_en     = 1'b1;
        w_state_next = ST_RUN;
      end
      ST_RUN: begin
        w_cmp_en   = 1'b1;
        w_lfsr_adv = 1'b1;
        w_vec_next = r_vec_cnt + 16'd1;
        if (r_vec_cnt == C_LAST_VEC) begin
          w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        w_cmp_en     = 1'b1;
        w_state_next = ST_DONE;
        w_busy_next  = 1'b0;
        w_done_next  = 1'b1;
      end
      default: w_state_next = ST_IDLE;
    endcase
    if (w_cmp_en && (ff.Q_I != w_exp_eff) && (r_err_cnt != 16'hFFFF)) begin
      w_err_next = r_err_cnt + 16'd1;
    end
  end

  // Stimulus for the coming cycle: a masked vector when it is a RUN cycle,
  // neutral otherwise, so a run's first vector is on the pins on RUN entry.
  always_comb begin
    w_d_next  = 1'b0;
    w_ce_next = C_CE_IDLE;
    w_sr_next = 1'b0;
    if (w_state_next == ST_RUN) begin
      w_d_next  = w_lfsr_bits[0];
      w_ce_next = C_HAS_CE ? (w_lfsr_bits[1] | w_lfsr_bits[2]) : 1'b1;
      w_sr_next = C_HAS_SR & w_lfsr_bits[3] & w_lfsr_bits[4] & w_lfsr_bits[5];
    end
  end

  // State, stimulus, flags, counters and the reference flop.
  always_ff @(posedge CLK or posedge CLEAR) begin
    if (CLEAR) begin
      r_state   <= ST_IDLE;
      r_d       <= 1'b0;
      r_ce      <= C_CE_IDLE;
      r_sr      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_err_cnt <= 16'd0;
      r_vec_cnt <= 16'd0;
      r_exp     <= INIT;
      r_settle  <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_d       <= w_d_next;
      r_ce      <= w_ce_next;
      r_sr      <= w_sr_next;
      r_busy    <= w_busy_next;
      r_done    <= w_done_next;
      r_pass    <= w_done_next && (w_err_next == 16'd0);
      r_err_cnt <= w_err_next;
      r_vec_cnt <= w_vec_next;
      r_exp     <= r_sr ? C_SR_VAL : (r_ce ? r_d : r_exp);
      r_settle  <= 1'b1;
    end
  end

  assign ff.D_O  = r_d;
  assign ff.CE_O = r_ce;
  assign ff.SR_O = r_sr;
  assign BUSY    = r_busy;
  assign DONE    = r_done;
  assign PASS    = r_pass;
  assign ERR_CNT = r_err_cnt;

endmodule

// File: tb/tb_gowin_ff_exerciser.sv
// Bench: four exercisers (CE/INIT=1, sync set, CE+async preset, CE+async
// clear) sharing CLK/CLEAR/START, each driving a behavioural flop.
module tb_gowin_ff_exerciser;

  logic clk = 1'b0;
  logic clear = 1'b0;
  logic start = 1'b0;
  logic tie0_1 = 1'b0;
  logic inv_2 = 1'b0;

  int checks = 0;
  int errors = 0;

  gowin_ff_exerciser_if if1();
  gowin_ff_exerciser_if if2();
  gowin_ff_exerciser_if if4();
  gowin_ff_exerciser_if if5();

  logic busy1, done_o1, pass1, busy2, done_o2, pass2;
  logic busy4, done_o4, pass4, busy5, done_o5, pass5;
  logic [15:0] err1, err2, err4, err5;
  logic q1, q2, q4, q5;

  always #5 clk = ~clk;

  gowin_ff_exerciser #(.MODE(1), .ASYNC(1'b0), .INIT(1'b1), .SEED(16'hACE1), .NUM_VECTORS(256)) u1 (
    .CLK(clk), .CLEAR(clear), .START(start), .ff(if1),
    .BUSY(busy1), .DONE(done_o1), .PASS(pass1), .ERR_CNT(err1));
  gowin_ff_exerciser #(.MODE(2), .ASYNC(1'b0), .INIT(1'b0), .SEED(16'hACE1), .NUM_VECTORS(256)) u2 (
    .CLK(clk), .CLEAR(clear), .START(start), .ff(if2),
    .BUSY(busy2), .DONE(done_o2), .PASS(pass2), .ERR_CNT(err2));
  gowin_ff_exerciser #(.MODE(4), .ASYNC(1'b1), .INIT(1'b0), .SEED(16'hACE1), .NUM_VECTORS(256)) u4 (
    .CLK(clk), .CLEAR(clear), .START(start), .ff(if4),
    .BUSY(busy4), .DONE(done_o4), .PASS(pass4), .ERR_CNT(err4));
  gowin_ff_exerciser #(.MODE(5), .ASYNC(1'b1), .INIT(1'b0), .SEED(16'hACE1), .NUM_VECTORS(256)) u5 (
    .CLK(clk), .CLEAR(clear), .START(start), .ff(if5),
    .BUSY(busy5), .DONE(done_o5), .PASS(pass5), .ERR_CNT(err5));

  // Flops under test; CLEAR returns them to their power-up value.
  always @(posedge clk or posedge clear)
    if (clear) q1 <= 1'b1; else if (if1.CE_O) q1 <= if1.D_O;
  always @(posedge clk or posedge clear)
    if (clear) q2 <= 1'b0; else if (if2.SR_O) q2 <= 1'b1; else if (if2.CE_O) q2 <= if2.D_O;
  always @(posedge clk or posedge clear or posedge if4.SR_O)
    if (clear) q4 <= 1'b0; else if (if4.SR_O) q4 <= 1'b1; else if (if4.CE_O) q4 <= if4.D_O;
  always @(posedge clk or posedge clear or posedge if5.SR_O)
    if (clear) q5 <= 1'b0; else if (if5.SR_O) q5 <= 1'b0; else if (if5.CE_O) q5 <= if5.D_O;

  assign if1.Q_I = tie0_1 ? 1'b0 : q1;
  assign if2.Q_I = inv_2 ? ~q2 : q2;
  assign if4.Q_I = q4;
  assign if5.Q_I = q5;

  // LFSR sequence from the seed: L[k] is the value behind RUN vector k.
  logic [15:0] lfsr_model [0:256];
  int model_sr_cnt;

  int done1, done2, done4, done5;
  int vec_err1, vec_err2, sr_cnt4, sr_cnt5;
  logic [15:0] err1_after_chk;

  task automatic build_model();
    logic [15:0] l;
    l = 16'hACE1;
    model_sr_cnt = 0;
    for (int k = 0; k <= 256; k++) begin
      lfsr_model[k] = l;
      if (k < 256 && l[3] && l[4] && l[5]) model_sr_cnt++;
      l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    end
  endtask

  // One START pulse (or held START), then follow all four runs to DONE.
  // c counts negedges after the START edge; u1/u4/u5 spend c=0 in CHK_INIT.
  task automatic run_all(input logic hold);
    int c;
    logic [15:0] l;
    logic ed1, ece1, ed2, esr2;
    done1 = -1; done2 = -1; done4 = -1; done5 = -1;
    vec_err1 = 0; vec_err2 = 0; sr_cnt4 = 0; sr_cnt5 = 0;
    err1_after_chk = 16'hDEAD;
    start = 1'b1;
    @(negedge clk);
    start = hold;
    c = 0;
    while (c < 400 && (done1 < 0 || done2 < 0 || done4 < 0 || done5 < 0)) begin
      if (c <= 258) begin
        ed1 = 1'b0; ece1 = 1'b0;
        if (c >= 1 && c <= 256) begin
          l = lfsr_model[c-1]; ed1 = l[0]; ece1 = l[1] | l[2];
        end
        if (if1.D_O !== ed1 || if1.CE_O !== ece1 || if1.SR_O !== 1'b0) vec_err1++;
        if (if4.SR_O === 1'b1) sr_cnt4++;
        if (if5.SR_O === 1'b1) sr_cnt5++;
      end
      if (c <= 257) begin
        ed2 = 1'b0; esr2 = 1'b0;
        if (c <= 255) begin
          l = lfsr_model[c]; ed2 = l[0]; esr2 = l[3] & l[4] & l[5];
        end
        if (if2.D_O !== ed2 || if2.SR_O !== esr2 || if2.CE_O !== 1'b1) vec_err2++;
      end
      if (c == 1) err1_after_chk = err1;
      if (done1 < 0 && done_o1) done1 = c;
      if (done2 < 0 && done_o2) done2 = c;
      if (done4 < 0 && done_o4) done4 = c;
      if (done5 < 0 && done_o5) done5 = c;
      @(negedge clk);
      c++;
    end
  endtask

  task automatic test_reset();
    start = 1'b0;
    #3 clear = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy1); end
    checks++; if (done_o1 !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", done_o1); end
    checks++; if (pass1 !== 1'b0) begin errors++; $display("FAIL reset_pass: got %0b want 0", pass1); end
    checks++; if (err1 !== 16'd0) begin errors++; $display("FAIL reset_err: got %0d want 0", err1); end
    checks++; if (if1.D_O !== 1'b0) begin errors++; $display("FAIL reset_d: got %0b want 0", if1.D_O); end
    checks++; if (if1.CE_O !== 1'b0) begin errors++; $display("FAIL reset_ce_mode1: got %0b want 0", if1.CE_O); end
    checks++; if (if4.SR_O !== 1'b0) begin errors++; $display("FAIL reset_sr_mode4: got %0b want 0", if4.SR_O); end
    checks++; if (if2.CE_O !== 1'b1) begin errors++; $display("FAIL reset_ce_mode2: got %0b want 1", if2.CE_O); end
    $display("test_reset: busy=%0b done=%0b err=%0d ce1=%0b ce2=%0b", busy1, done_o1, err1, if1.CE_O, if2.CE_O);
  endtask

  task automatic test_settle();
    clear = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL settle_busy1: got %0b want 0", busy1); end
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL settle_busy2: got %0b want 0", busy2); end
    repeat (2) @(negedge clk);
    $display("test_settle: START right after CLEAR -> busy1=%0b busy2=%0b", busy1, busy2);
  endtask

  task automatic test_ce_run();
    run_all(1'b0);
    checks++; if (done1 != 258) begin errors++; $display("FAIL ce_latency: got %0d want 258", done1); end
    checks++; if (done2 != 257) begin errors++; $display("FAIL noce_latency: got %0d want 257", done2); end
    checks++; if (done4 != 258) begin errors++; $display("FAIL preset_latency: got %0d want 258", done4); end
    checks++; if (err1 !== 16'd0) begin errors++; $display("FAIL ce_err: got %0d want 0", err1); end
    checks++; if (pass1 !== 1'b1) begin errors++; $display("FAIL ce_pass: got %0b want 1", pass1); end
    checks++; if (pass2 !== 1'b1) begin errors++; $display("FAIL set_pass: got %0b want 1 (err %0d)", pass2, err2); end
    checks++; if (pass4 !== 1'b1) begin errors++; $display("FAIL preset_pass: got %0b want 1 (err %0d)", pass4, err4); end
    checks++; if (pass5 !== 1'b1) begin errors++; $display("FAIL clear_pass: got %0b want 1 (err %0d)", pass5, err5); end
    checks++; if (vec_err1 != 0) begin errors++; $display("FAIL ce_vectors: got %0d bad cycles want 0", vec_err1); end
    checks++; if (vec_err2 != 0) begin errors++; $display("FAIL set_vectors: got %0d bad cycles want 0", vec_err2); end
    checks++; if (sr_cnt4 != model_sr_cnt) begin errors++; $display("FAIL preset_sr_pulses: got %0d want %0d", sr_cnt4, model_sr_cnt); end
    checks++; if (sr_cnt5 != model_sr_cnt) begin errors++; $display("FAIL clear_sr_pulses: got %0d want %0d", sr_cnt5, model_sr_cnt); end
    checks++; if (sr_cnt4 < 20 || sr_cnt4 > 44) begin errors++; $display("FAIL sr_rate: got %0d want 20..44", sr_cnt4); end
    $display("test_ce_run: done1=%0d done2=%0d err1=%0d err2=%0d err4=%0d err5=%0d sr=%0d", done1, done2, err1, err2, err4, err5, sr_cnt4);
  endtask

  task automatic test_bad_q();
    tie0_1 = 1'b1;
    inv_2 = 1'b1;
    run_all(1'b0);
    checks++; if (err1_after_chk !== 16'd1) begin errors++; $display("FAIL chk_init_count: got %0d want 1", err1_after_chk); end
    checks++; if (err1 <= 16'd100) begin errors++; $display("FAIL tie0_err: got %0d want >100", err1); end
    checks++; if (pass1 !== 1'b0) begin errors++; $display("FAIL tie0_pass: got %0b want 0", pass1); end
    checks++; if (done_o1 !== 1'b1) begin errors++; $display("FAIL tie0_done: got %0b want 1", done_o1); end
    // Every compare cycle of the no-CE run (256 RUN + 1 DRAIN) mismatches.
    checks++; if (err2 !== 16'd257) begin errors++; $display("FAIL inv_err: got %0d want 257", err2); end
    checks++; if (pass2 !== 1'b0) begin errors++; $display("FAIL inv_pass: got %0b want 0", pass2); end
    checks++; if (vec_err1 != 0) begin errors++; $display("FAIL restart_vectors: got %0d bad cycles want 0", vec_err1); end
    tie0_1 = 1'b0;
    inv_2 = 1'b0;
    $display("test_bad_q: chk_init_err=%0d err1=%0d err2=%0d pass1=%0b pass2=%0b", err1_after_chk, err1, err2, pass1, pass2);
  endtask

  task automatic test_clear_abort();
    inv_2 = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    checks++; if (err2 !== 16'd100) begin errors++; $display("FAIL abort_pre_err: got %0d want 100", err2); end
    #2 clear = 1'b1;
    #1;
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL abort_busy: got %0b want 0", busy2); end
    checks++; if (err2 !== 16'd0) begin errors++; $display("FAIL abort_err: got %0d want 0", err2); end
    checks++; if (if2.D_O !== 1'b0) begin errors++; $display("FAIL abort_d: got %0b want 0", if2.D_O); end
    checks++; if (if2.CE_O !== 1'b1) begin errors++; $display("FAIL abort_ce2: got %0b want 1", if2.CE_O); end
    checks++; if (if1.CE_O !== 1'b0) begin errors++; $display("FAIL abort_ce1: got %0b want 0", if1.CE_O); end
    checks++; if (if4.SR_O !== 1'b0) begin errors++; $display("FAIL abort_sr4: got %0b want 0", if4.SR_O); end
    checks++; if (done_o1 !== 1'b0) begin errors++; $display("FAIL abort_done: got %0b want 0", done_o1); end
    @(negedge clk);
    clear = 1'b0;
    inv_2 = 1'b0;
    repeat (2) @(negedge clk);
    run_all(1'b0);
    checks++; if (vec_err1 != 0) begin errors++; $display("FAIL rerun_vectors1: got %0d bad cycles want 0", vec_err1); end
    checks++; if (vec_err2 != 0) begin errors++; $display("FAIL rerun_vectors2: got %0d bad cycles want 0", vec_err2); end
    checks++; if (done2 != 257) begin errors++; $display("FAIL rerun_latency: got %0d want 257", done2); end
    checks++; if (pass1 !== 1'b1 || pass2 !== 1'b1) begin errors++; $display("FAIL rerun_pass: got %0b%0b want 11", pass1, pass2); end
    checks++; if (pass4 !== 1'b1 || pass5 !== 1'b1) begin errors++; $display("FAIL rerun_pass_async: got %0b%0b want 11", pass4, pass5); end
    $display("test_clear_abort: rerun done2=%0d vec_err1=%0d vec_err2=%0d err1=%0d err2=%0d", done2, vec_err1, vec_err2, err1, err2);
  endtask

  task automatic test_start_held();
    run_all(1'b1);
    start = 1'b0;
    checks++; if (done1 != 258) begin errors++; $display("FAIL held_latency_ce: got %0d want 258", done1); end
    checks++; if (done2 != 257) begin errors++; $display("FAIL held_latency_noce: got %0d want 257", done2); end
    checks++; if (vec_err2 != 0) begin errors++; $display("FAIL held_vectors: got %0d bad cycles want 0", vec_err2); end
    $display("test_start_held: done1=%0d done2=%0d", done1, done2);
  endtask

  initial begin
    build_model();
    test_reset();
    test_settle();
    test_ce_run();
    test_bad_q();
    test_clear_abort();
    test_start_held();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
